outmux_rx: RTL
==============

OUTMUX_RX -- requirements
Module: outmux_rx

Interface
REQ-001 Parameter LINK_DLY, default 0, range 0..3: pipeline delay in clk cycles between the transmitter mux output and y_in.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 y_in  input  8  time-multiplexed byte stream from the 4-byte output mux.
REQ-005 align  input  1  synchronous resync request; restarts the slot counter.
REQ-006 d0, d1, d2, d3  output  8 each  last complete frame, registered.
REQ-007 frame_valid  output  1  one-cycle pulse when d0..d3 update.
REQ-008 frame_cnt  output  8  number of committed frames, modulo 256.
REQ-009 idle_err  output  1  sticky idle-slot violation flag (see Configuration).

Function
REQ-010 A 3-bit slot counter SHALL increment by 1 each cycle and wrap 7->0, matching the transmitter's 8-slot frame.
REQ-011 Capture slot for byte k (k=0..3) SHALL be (2 + k + LINK_DLY) mod 8; all other counter values are idle slots.
REQ-012 At the edge where counter equals the slot of byte 0, 1 or 2, y_in SHALL be stored into internal shadow register 0, 1 or 2; outputs are unchanged.
REQ-013 At the edge where counter equals the byte-3 slot, d0..d2 SHALL load the shadows, d3 SHALL load y_in, frame_valid SHALL go 1, and frame_cnt SHALL increment; all of this happens on that same edge.
REQ-014 frame_valid SHALL be 1 for exactly one cycle per commit and 0 otherwise.
REQ-015 d0..d3 SHALL update atomically: they never show a mix of two frames.
REQ-016 Frame rate SHALL be one commit per 8 cycles in steady state.
REQ-017 frame_cnt SHALL wrap 255->0 without any other effect.
REQ-018 align=1 SHALL set the counter to 0 at the next edge, overriding increment. The partial frame SHALL be discarded: no commit and no frame_valid on that edge, even if the counter held the byte-3 slot.
REQ-019 align SHALL NOT change d0..d3 or frame_cnt.
REQ-020 Holding align high SHALL keep the counter at 0. The next capture sequence SHALL start relative to the first cycle with align=0.

Reset
REQ-021 While rst=1: counter=0, shadows=0, d0..d3=0, frame_valid=0, frame_cnt=0, idle_err=0.
REQ-022 Reset SHALL take effect asynchronously. Reset asserted mid-frame SHALL discard the partial frame.
REQ-023 After rst is released, the first rising edge SHALL sample counter value 0. With LINK_DLY=0, the first commit SHALL occur at the 6th edge and every 8th edge after that.

Configuration
REQ-024 Macro OUTMUX_RX_IDLE_CHECK_EN defined: at any edge where the counter is in an idle slot, align=0, and y_in!=0, idle_err SHALL set to 1.
REQ-025 With OUTMUX_RX_IDLE_CHECK_EN defined, idle_err SHALL stay set until rst or align=1; align clears it at the next edge.
REQ-026 Macro OUTMUX_RX_IDLE_CHECK_EN undefined: idle_err SHALL be tied to 0 and no check logic SHALL be present; the port remains.

Verification
REQ-027 Reset release, LINK_DLY=0, stream 00,00,A1,B2,C3,D4,00,00 repeating -> at edge 6 d0..d3=A1,B2,C3,D4, frame_valid pulses at edges 6,14,22, frame_cnt=1,2,3.
REQ-028 LINK_DLY=2, same stream delayed 2 cycles -> identical d0..d3 values, first commit at edge 8.
REQ-029 Mid-frame align asserted while counter=4 -> no commit that frame, d0..d3 hold previous values, next commit 6 edges after align is released.
REQ-030 Run 256 frames -> frame_cnt wraps to 0 on the 256th commit, frame_valid pulses normally.
REQ-031 With OUTMUX_RX_IDLE_CHECK_EN, y_in=0x55 in slot 7 -> idle_err=1 after that edge; it stays 1 through later clean frames; align pulse -> 0. Without the macro -> idle_err stays 0.
REQ-032 rst pulsed between clock edges at counter=3 -> all outputs 0 immediately, and realignment follows REQ-023.

Source files
------------

// File: rtl/outmux_rx.sv
// Receiver for the 8-slot time-multiplexed byte stream of a 4-byte output mux.
// Optional idle-slot checking is enabled by defining OUTMUX_RX_IDLE_CHECK_EN.
module outmux_rx #(
    parameter int LINK_DLY = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] y_in,
    input  logic       align,
    output logic [7:0] d0,
    output logic [7:0] d1,
    output logic [7:0] d2,
    output logic [7:0] d3,
    output logic       frame_valid,
    output logic [7:0] frame_cnt,
    output logic       idle_err
);

    localparam logic [2:0] SLOT0 = 3'((2 + LINK_DLY) % 8);
    localparam logic [2:0] SLOT1 = 3'((3 + LINK_DLY) % 8);
    localparam logic [2:0] SLOT2 = 3'((4 + LINK_DLY) % 8);
    localparam logic [2:0] SLOT3 = 3'((5 + LINK_DLY) % 8);

    logic [2:0] slot_cnt;
    logic [7:0] shadow0;
    logic [7:0] shadow1;
    logic [7:0] shadow2;
    logic       cap0;
    logic       cap1;
    logic       cap2;
    logic       commit;

    // An align request suppresses every capture and commit on its edge.
    always_comb begin
        cap0   = 1'b0;
        cap1   = 1'b0;
        cap2   = 1'b0;
        commit = 1'b0;
        if (!align) begin
            cap0   = (slot_cnt == SLOT0);
            cap1   = (slot_cnt == SLOT1);
            cap2   = (slot_cnt == SLOT2);
            commit = (slot_cnt == SLOT3);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_cnt <= 3'd0;
            shadow0  <= 8'h00;
            shadow1  <= 8'h00;
            shadow2  <= 8'h00;
        end else begin
            slot_cnt <= align ? 3'd0 : slot_cnt + 3'd1;
            if (cap0) shadow0 <= y_in;
            if (cap1) shadow1 <= y_in;
            if (cap2) shadow2 <= y_in;
        end
    end

    // All four output bytes load together so a frame is never shown half-updated.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d0          <= 8'h00;
            d1          <= 8'h00;
            d2          <= 8'h00;
            d3          <= 8'h00;
            frame_valid <= 1'b0;
            frame_cnt   <= 8'h00;
        end else begin
            frame_valid <= commit;
            if (commit) begin
                d0        <= shadow0;
                d1        <= shadow1;
                d2        <= shadow2;
                d3        <= y_in;
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

`ifdef OUTMUX_RX_IDLE_CHECK_EN
    logic idle_slot;

    always_comb begin
        idle_slot = (slot_cnt != SLOT0) && (slot_cnt != SLOT1) &&
                    (slot_cnt != SLOT2) && (slot_cnt != SLOT3);
    end

    // Sticky until reset or a resync request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_err <= 1'b0;
        end else if (align) begin
            idle_err <= 1'b0;
        end else if (idle_slot && (y_in != 8'h00)) begin
            idle_err <= 1'b1;
        end
    end
`else
    assign idle_err = 1'b0;
`endif

endmodule
